// File: rtl/fighter_pkg.sv
// fighter_pkg: shared action/attack-kind types and default key codes for fighter_action_ctrl.
package fighter_pkg;
  typedef enum logic [2:0] {IDLE, STARTUP, ACTIVE, RECOVERY, HITSTUN} action_t;
  typedef enum logic {PUNCH, KICK} attack_kind_t;
  localparam logic [7:0] DEF_KEY_JUMP   = 8'h0C;
  localparam logic [7:0] DEF_KEY_LEFT   = 8'h0D;
  localparam logic [7:0] DEF_KEY_CROUCH = 8'h0E;
  localparam logic [7:0] DEF_KEY_RIGHT  = 8'h0F;
  localparam logic [7:0] DEF_KEY_PUNCH  = 8'h12;
  localparam logic [7:0] DEF_KEY_KICK   = 8'h13;
endpackage

// File: rtl/keyslot_match.sv
// keyslot_match: flags one key code as held in any of the four slots, plus its registered rising edge.
module keyslot_match #(
  parameter logic [7:0] CODE = 8'h00
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode_0,
  input  logic [7:0] keycode_1,
  input  logic [7:0] keycode_2,
  input  logic [7:0] keycode_3,
  output logic       held,
  output logic       pressed
);
  logic prev;
  assign held = keycode_0 == CODE || keycode_1 == CODE || keycode_2 == CODE || keycode_3 == CODE;
  assign pressed = held && !prev;
  always_ff @(posedge frame_clk) prev <= Reset_n ? held : 1'b0;
endmodule

// File: rtl/fighter_action_ctrl.sv
// fighter_action_ctrl: per-player keycode-to-action sequencer with timed attack phases, hitstun and knockback.
// Define COMBO_CANCEL_EN to let a press during RECOVERY of a connected attack cancel into a new attack.
module fighter_action_ctrl
  import fighter_pkg::*;
#(
  parameter logic [7:0] KEY_JUMP   = DEF_KEY_JUMP,
  parameter logic [7:0] KEY_LEFT   = DEF_KEY_LEFT,
  parameter logic [7:0] KEY_CROUCH = DEF_KEY_CROUCH,
  parameter logic [7:0] KEY_RIGHT  = DEF_KEY_RIGHT,
  parameter logic [7:0] KEY_PUNCH  = DEF_KEY_PUNCH,
  parameter logic [7:0] KEY_KICK   = DEF_KEY_KICK,
  parameter int PUNCH_STARTUP  = 3,
  parameter int PUNCH_ACTIVE   = 2,
  parameter int PUNCH_RECOVERY = 6,
  parameter int KICK_STARTUP   = 5,
  parameter int KICK_ACTIVE    = 3,
  parameter int KICK_RECOVERY  = 10,
  parameter int PUNCH_RANGE    = 150,
  parameter int KICK_RANGE     = 190,
  parameter int HITSTUN_FRAMES = 12,
  parameter int KB_MAG         = 3,
  parameter int KB_FRAMES      = 4,
  parameter int FACE_LEFT      = 1
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic [7:0]         keycode_0,
  input  logic [7:0]         keycode_1,
  input  logic [7:0]         keycode_2,
  input  logic [7:0]         keycode_3,
  input  logic [9:0]         XDist,
  input  logic               InAir,
  input  logic               OppBlocking,
  input  logic               GotHit,
  output logic               WalkLeft,
  output logic               WalkRight,
  output logic               Crouch,
  output logic               JumpReq,
  output action_t            Action,
  output attack_kind_t       AttackKind,
  output logic               HitPulse,
  output logic signed [9:0]  Knockback
);
  localparam logic [5:0][7:0] CODES = {KEY_KICK, KEY_PUNCH, KEY_RIGHT, KEY_CROUCH, KEY_LEFT, KEY_JUMP};
  localparam logic signed [9:0] KB_VAL = FACE_LEFT != 0 ? 10'(-KB_MAG) : 10'(KB_MAG);
  logic [5:0] held, pressed;
  logic [4:0] cnt, nxt_cnt, kb_cnt;
  action_t nxt_act;
  attack_kind_t nxt_kind;
  logic hit_landed, hit, cancel_ok, start_k, begin_atk, in_range, to_idle, unused_bits;
  for (genvar k = 0; k < 6; k++) begin : g_key
    keyslot_match #(.CODE(CODES[k])) u_key (
      .frame_clk(frame_clk),
      .Reset_n(Reset_n),
      .keycode_0(keycode_0),
      .keycode_1(keycode_1),
      .keycode_2(keycode_2),
      .keycode_3(keycode_3),
      .held(held[k]),
      .pressed(pressed[k])
    );
  end
  function automatic logic [4:0] phase_len(input attack_kind_t kd, input action_t ph);
    return ph == STARTUP ? 5'(kd == KICK ? KICK_STARTUP : PUNCH_STARTUP) :
           ph == ACTIVE  ? 5'(kd == KICK ? KICK_ACTIVE : PUNCH_ACTIVE) :
                           5'(kd == KICK ? KICK_RECOVERY : PUNCH_RECOVERY);
  endfunction
`ifdef COMBO_CANCEL_EN
  assign cancel_ok = Action == RECOVERY && hit_landed;
`else
  assign cancel_ok = 1'b0;
`endif
  // a cancel is already airborne-agnostic; only a fresh kick from IDLE needs ground contact
  assign start_k = pressed[5] && (cancel_ok || !InAir);
  assign begin_atk = (Action == IDLE || cancel_ok) && (pressed[4] || start_k);
  assign in_range = XDist <= (AttackKind == KICK ? 10'(KICK_RANGE) : 10'(PUNCH_RANGE));
  assign to_idle = nxt_act == IDLE;
  assign unused_bits = ^{held[5:4], pressed[3:0]};
  always_comb begin
    nxt_act = Action;
    nxt_kind = AttackKind;
    nxt_cnt = cnt == 5'd0 ? 5'd0 : cnt - 5'd1;
    hit = 1'b0;
    if (GotHit) begin
      nxt_act = HITSTUN;
      nxt_cnt = 5'(HITSTUN_FRAMES - 1);
    end else if (begin_atk) begin
      nxt_act = STARTUP;
      nxt_kind = pressed[4] ? PUNCH : KICK;
      nxt_cnt = phase_len(nxt_kind, STARTUP) - 5'd1;
    end else if (cnt == 5'd0 && Action != IDLE) begin
      nxt_act = Action == STARTUP ? ACTIVE : Action == ACTIVE ? RECOVERY : IDLE;
      nxt_cnt = nxt_act == IDLE ? 5'd0 : phase_len(AttackKind, nxt_act) - 5'd1;
      hit = Action == STARTUP && in_range && !OppBlocking && !hit_landed;
    end
  end
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      Action <= IDLE;
      AttackKind <= PUNCH;
      cnt <= 5'd0;
      kb_cnt <= 5'd0;
      hit_landed <= 1'b0;
      HitPulse <= 1'b0;
      Knockback <= '0;
      WalkLeft <= 1'b0;
      WalkRight <= 1'b0;
      Crouch <= 1'b0;
      JumpReq <= 1'b0;
    end else begin
      Action <= nxt_act;
      AttackKind <= nxt_kind;
      cnt <= nxt_cnt;
      hit_landed <= !(to_idle || begin_atk) && (hit || hit_landed);
      HitPulse <= hit;
      kb_cnt <= hit ? 5'(KB_FRAMES) : kb_cnt == 5'd0 ? 5'd0 : kb_cnt - 5'd1;
      Knockback <= kb_cnt != 5'd0 ? KB_VAL : '0;
      Crouch <= to_idle && held[2];
      WalkLeft <= to_idle && held[1] && !held[3] && !held[2];
      WalkRight <= to_idle && held[3] && !held[1] && !held[2];
      JumpReq <= to_idle && held[0] && !held[2] && !InAir;
    end
  end
endmodule

// File: tb/tb_fighter_action_ctrl.sv
// tb_fighter_action_ctrl: directed scoreboard bench for fighter_action_ctrl.
module tb_fighter_action_ctrl;
  import fighter_pkg::*;
  localparam logic [9:0] KB_NEG = 10'h3FD;
  logic frame_clk, Reset_n, InAir, OppBlocking, GotHit;
  logic [7:0] keycode_0, keycode_1, keycode_2, keycode_3;
  logic [9:0] XDist;
  logic WalkLeft, WalkRight, Crouch, JumpReq, HitPulse;
  action_t Action;
  attack_kind_t AttackKind;
  logic signed [9:0] Knockback;
  logic [18:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  fighter_action_ctrl dut (
    .frame_clk(frame_clk),
    .Reset_n(Reset_n),
    .keycode_0(keycode_0),
    .keycode_1(keycode_1),
    .keycode_2(keycode_2),
    .keycode_3(keycode_3),
    .XDist(XDist),
    .InAir(InAir),
    .OppBlocking(OppBlocking),
    .GotHit(GotHit),
    .WalkLeft(WalkLeft),
    .WalkRight(WalkRight),
    .Crouch(Crouch),
    .JumpReq(JumpReq),
    .Action(Action),
    .AttackKind(AttackKind),
    .HitPulse(HitPulse),
    .Knockback(Knockback)
  );
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;
  // mv = {WalkLeft, WalkRight, Crouch, JumpReq}
  task automatic cyc(input string tag, input action_t a, input attack_kind_t k, input logic hp,
                     input logic [9:0] kb, input logic [3:0] mv);
    logic [18:0] e, o;
    exp_q.push_back({a, k, hp, kb, mv});
    @(posedge frame_clk);
    #1;
    e = exp_q.pop_front();
    o = {Action, AttackKind, HitPulse, Knockback, WalkLeft, WalkRight, Crouch, JumpReq};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic attack(input attack_kind_t k, input logic exp_hit, input logic hold, input int nf);
    int s, a, r;
    action_t ea;
    s = k == KICK ? 5 : 3;
    a = k == KICK ? 3 : 2;
    r = k == KICK ? 10 : 6;
    keycode_0 = k == KICK ? 8'h13 : 8'h12;
    for (int f = 1; f <= s + a + r + 1 && f <= nf; f++) begin
      ea = f <= s ? STARTUP : f <= s + a ? ACTIVE : f <= s + a + r ? RECOVERY : IDLE;
      cyc($sformatf("%s_x%0d_f%0d", k == KICK ? "kick" : "punch", XDist, f), ea, k,
          exp_hit && f == s + 1, (exp_hit && f >= s + 2 && f <= s + 5) ? KB_NEG : 10'd0, 4'b0000);
      if (!hold) keycode_0 = 8'h00;
    end
  endtask
  initial begin
    Reset_n = 1'b0;
    keycode_0 = 8'h0D;
    keycode_1 = 8'h0C;
    keycode_2 = 8'h00;
    keycode_3 = 8'h00;
    XDist = 10'd100;
    InAir = 1'b0;
    OppBlocking = 1'b0;
    GotHit = 1'b0;
    cyc("reset0", IDLE, PUNCH, 0, 0, 4'b0000);
    cyc("reset1", IDLE, PUNCH, 0, 0, 4'b0000);
    keycode_0 = 8'h00;
    keycode_1 = 8'h00;
    Reset_n = 1'b1;
    cyc("idle", IDLE, PUNCH, 0, 0, 4'b0000);
    attack(PUNCH, 1'b1, 1'b1, 99);
    cyc("punch_held_no_repeat", IDLE, PUNCH, 0, 0, 4'b0000);
    keycode_0 = 8'h13;
    InAir = 1'b1;
    cyc("kick_in_air", IDLE, PUNCH, 0, 0, 4'b0000);
    keycode_0 = 8'h00;
    InAir = 1'b0;
    cyc("kick_release", IDLE, PUNCH, 0, 0, 4'b0000);
    XDist = 10'd200;
    attack(KICK, 1'b0, 1'b0, 99);
    XDist = 10'd190;
    attack(KICK, 1'b1, 1'b0, 99);
    XDist = 10'd151;
    attack(PUNCH, 1'b0, 1'b0, 99);
    XDist = 10'd150;
    attack(PUNCH, 1'b1, 1'b0, 99);
    XDist = 10'd100;
    OppBlocking = 1'b1;
    attack(PUNCH, 1'b0, 1'b0, 99);
    OppBlocking = 1'b0;
    XDist = 10'd200;
    keycode_0 = 8'h13;
    cyc("hs_kick_start", STARTUP, KICK, 0, 0, 4'b0000);
    keycode_0 = 8'h00;
    keycode_1 = 8'h12;
    cyc("hs_punch_dropped", STARTUP, KICK, 0, 0, 4'b0000);
    GotHit = 1'b1;
    cyc("hs_enter", HITSTUN, KICK, 0, 0, 4'b0000);
    GotHit = 1'b0;
    for (int i = 2; i <= 6; i++) cyc($sformatf("hs_first_%0d", i), HITSTUN, KICK, 0, 0, 4'b0000);
    GotHit = 1'b1;
    cyc("hs_reload", HITSTUN, KICK, 0, 0, 4'b0000);
    GotHit = 1'b0;
    for (int i = 1; i <= 11; i++) cyc($sformatf("hs_second_%0d", i), HITSTUN, KICK, 0, 0, 4'b0000);
    cyc("hs_exit", IDLE, KICK, 0, 0, 4'b0000);
    cyc("hs_punch_held", IDLE, KICK, 0, 0, 4'b0000);
    keycode_1 = 8'h00;
    keycode_0 = 8'h0D;
    keycode_1 = 8'h0F;
    cyc("left_right", IDLE, KICK, 0, 0, 4'b0000);
    keycode_1 = 8'h00;
    cyc("left_only", IDLE, KICK, 0, 0, 4'b1000);
    keycode_1 = 8'h0E;
    cyc("crouch_left", IDLE, KICK, 0, 0, 4'b0010);
    keycode_0 = 8'h0F;
    keycode_1 = 8'h00;
    cyc("right_only", IDLE, KICK, 0, 0, 4'b0100);
    keycode_0 = 8'h00;
    keycode_3 = 8'h0C;
    InAir = 1'b1;
    cyc("jump_in_air", IDLE, KICK, 0, 0, 4'b0000);
    InAir = 1'b0;
    cyc("jump_ground", IDLE, KICK, 0, 0, 4'b0001);
    keycode_3 = 8'h00;
    cyc("keys_off", IDLE, KICK, 0, 0, 4'b0000);
    XDist = 10'd100;
    attack(PUNCH, 1'b1, 1'b0, 5);
    Reset_n = 1'b0;
    cyc("reset_mid_attack", IDLE, PUNCH, 0, 0, 4'b0000);
    Reset_n = 1'b1;
    cyc("after_reset_kb_clear", IDLE, PUNCH, 0, 0, 4'b0000);
    attack(PUNCH, 1'b1, 1'b0, 6);
    keycode_0 = 8'h13;
`ifdef COMBO_CANCEL_EN
    cyc("combo_cancel", STARTUP, KICK, 0, KB_NEG, 4'b0000);
`else
    cyc("no_combo_cancel", RECOVERY, PUNCH, 0, KB_NEG, 4'b0000);
`endif
    keycode_0 = 8'h00;
    Reset_n = 1'b0;
    cyc("final_reset", IDLE, PUNCH, 0, 0, 4'b0000);
    Reset_n = 1'b1;
    cyc("final_idle", IDLE, PUNCH, 0, 0, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fighter_action_ctrl.md
Name: fighter_action_ctrl

Overview:
Per-player action sequencer that sits between the keyboard keycode bus and one fighter's movement/jump datapath. It turns the four keycode slots into at most one action per frame. It runs timed attack phases (startup/active/recovery) and hitstun on frame counters. It drives walk/crouch/jump requests to the movement block and a knockback value that the top level adds to the opponent's X update.

Parameters:
KEY_JUMP, 8'h0C, jump key
KEY_LEFT, 8'h0D, walk-left key
KEY_CROUCH, 8'h0E, crouch key
KEY_RIGHT, 8'h0F, walk-right key
KEY_PUNCH, 8'h12, punch key
KEY_KICK, 8'h13, kick key
PUNCH_STARTUP / PUNCH_ACTIVE / PUNCH_RECOVERY, 3 / 2 / 6, punch phase lengths in frames (each 1..31)
KICK_STARTUP / KICK_ACTIVE / KICK_RECOVERY, 5 / 3 / 10, kick phase lengths in frames (each 1..31)
PUNCH_RANGE, 150, max XDist for a punch to connect
KICK_RANGE, 190, max XDist for a kick to connect
HITSTUN_FRAMES, 12, lockout frames after being hit
KB_MAG, 3, knockback magnitude in pixels/frame
KB_FRAMES, 4, frames that knockback is applied
FACE_LEFT, 1, 1 = opponent is to the left, so knockback is negative

Ports:
frame_clk  in  1  frame clock (one edge per video frame)
Reset_n  in  1  synchronous active-low reset
keycode_0..keycode_3  in  8 each  keyboard slots
XDist  in  10  unsigned horizontal distance between fighters
InAir  in  1  jump in progress (from jump control)
OppBlocking  in  1  opponent is crouch-blocking
GotHit  in  1  opponent's hit pulse on this player
WalkLeft, WalkRight, Crouch, JumpReq  out  1 each  movement requests
Action  out  3  fighter_pkg::action_t current state
AttackKind  out  1  0 = punch, 1 = kick (valid outside IDLE/HITSTUN)
HitPulse  out  1  one-frame pulse when this player's attack connects
Knockback  out  10  signed knockback to add to the opponent's X position

Behaviour:
- Single clock frame_clk; reset is synchronous, active-low (Reset_n sampled on the frame_clk edge).
- Reset: Action=IDLE, phase counter=0, KB counter=0, all 1-bit outputs 0, Knockback=0, previous-key flags cleared.
- Key match: a key is "held" if any of the 4 slots equals its code. Punch and kick are "pressed" only on the rising edge of held (registered previous flag), so holding a key never repeats the attack.
- States: IDLE, STARTUP, ACTIVE, RECOVERY, HITSTUN. The phase counter loads (length-1) on entry and decrements each frame. The state advances when the counter is 0 and it is not reloaded.
- Priority each frame: GotHit > attack press > movement.
- GotHit in any state -> HITSTUN, counter=HITSTUN_FRAMES-1. GotHit during HITSTUN reloads the counter. HITSTUN -> IDLE on expiry.
- IDLE + punch press -> STARTUP(punch). IDLE + kick press with !InAir -> STARTUP(kick); a kick press while InAir is ignored. Simultaneous punch+kick press -> punch.
- STARTUP -> ACTIVE -> RECOVERY -> IDLE using the selected kind's lengths. Presses outside IDLE are dropped.
- Hit check on the first ACTIVE frame only: if XDist <= range(kind) and !OppBlocking, then HitPulse=1 for that frame, KB counter=KB_FRAMES, and the hit_landed flag is set (flag is cleared on entry to IDLE). At most one hit per attack.
- Knockback = FACE_LEFT ? -KB_MAG : +KB_MAG while KB counter>0, else 0. The KB counter decrements every frame independent of state, including through own HITSTUN. A new hit reloads it.
- Movement (registered, IDLE only, otherwise 0):
  - Crouch = crouch held.
  - WalkLeft = left held & !right & !crouch.
  - WalkRight = right held & !left & !crouch.
  - JumpReq = jump held & !crouch & !InAir.
- Reset mid-attack or mid-hitstun returns to IDLE next edge. No outputs glitch: all outputs are registered.

Optional Feature:
COMBO_CANCEL_EN
- Defined: in RECOVERY with hit_landed=1, a punch or kick press cancels to STARTUP of the new kind. hit_landed clears and the new attack can hit again.
- Undefined: presses in RECOVERY are ignored.

Decomposition:
- fighter_pkg: action_t enum (IDLE, STARTUP, ACTIVE, RECOVERY, HITSTUN), attack_kind_t, default key code constants.
- Sub-module keyslot_match: 4-slot compare plus registered edge detect for one key code. Outputs held and pressed; instantiated six times.

Test Plan:
- Reset_n=0 for 2 frames with keys held -> all outputs 0, Action=IDLE, Knockback=0.
- Punch edge at frame 0, XDist=100, OppBlocking=0:
  - STARTUP frames 1-3, ACTIVE 4-5, RECOVERY 6-11, IDLE at 12.
  - HitPulse only at frame 4.
  - Knockback=-3 for frames 5-8.
- Kick press with InAir=1 -> stays IDLE. Kick with InAir=0, XDist=200 -> full 5/3/10 sequence, HitPulse never asserted.
- GotHit during kick STARTUP -> HITSTUN 12 frames; second GotHit at hitstun frame 6 -> IDLE 12 frames after it. Punch held throughout -> no attack afterwards.
- Left+right held -> no walk. Crouch+left -> Crouch=1, WalkLeft=0. Jump with InAir=1 -> JumpReq=0.
- COMBO_CANCEL_EN: connected punch, kick press at first RECOVERY frame -> next frame STARTUP(kick). Without the macro -> remains RECOVERY.
